// File: rtl/ysyx_22040088_pkg.sv
// Shared definitions for the ysyx_22040088 instruction fetch unit:
// FSM state encoding, reset defaults and PC alignment helper.
package ysyx_22040088_pkg;

    localparam logic [1:0] IFU_IDLE = 2'd0;
    localparam logic [1:0] IFU_REQ  = 2'd1;
    localparam logic [1:0] IFU_WAIT = 2'd2;
    localparam logic [1:0] IFU_HOLD = 2'd3;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

    // Jump targets are word aligned by dropping the low two bits; no trap is raised.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch stage: owns the architectural PC, fetches one word at a time
// over a valid/ready + rvalid memory port and hands {inst, pc} to decode.
module ysyx_22040088_ifu
    import ysyx_22040088_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc
);

    logic [1:0]  state;
    logic [63:0] pc;
    logic [63:0] req_addr;
    logic        discard;
    logic [63:0] redirect_target;

    assign redirect_target = align_pc(redirect_pc);

    // The request port is a pure function of state so the address cannot move under a pending request.
    assign imem_req_valid = (state == IFU_REQ);
    assign imem_addr      = req_addr;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IFU_IDLE;
            pc       <= RESET_PC;
            req_addr <= '0;
            discard  <= 1'b0;
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= '0;
        end else begin
            if (redirect_valid && state != IFU_IDLE) begin
                pc <= redirect_target;
            end

            case (state)
                IFU_IDLE: begin
                    req_addr <= pc;
                    state    <= IFU_REQ;
                end

                IFU_REQ: begin
                    // A presented request stays as issued; its response is dropped later.
                    if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state <= IFU_WAIT;
                    end
                end

                IFU_WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect_valid) begin
                            discard  <= 1'b0;
                            req_addr <= redirect_target;
                            state    <= IFU_REQ;
                        end else if (discard) begin
                            discard  <= 1'b0;
                            req_addr <= pc;
                            state    <= IFU_REQ;
                        end else begin
                            id_inst  <= imem_rdata;
                            id_pc    <= req_addr;
                            id_valid <= 1'b1;
                            state    <= IFU_HOLD;
                        end
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end

                IFU_HOLD: begin
                    // Redirect takes priority over a same-cycle decode handshake.
                    if (redirect_valid) begin
                        id_valid <= 1'b0;
                        id_inst  <= NOP_INST;
                        req_addr <= redirect_target;
                        state    <= IFU_REQ;
                    end else if (id_ready) begin
                        pc       <= pc + 64'd4;
                        req_addr <= pc + 64'd4;
                        id_valid <= 1'b0;
                        id_inst  <= NOP_INST;
                        state    <= IFU_REQ;
                    end
                end

                default: begin
                    state <= IFU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Self-checking bench for ysyx_22040088_ifu: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ysyx_22040088_ifu;

    localparam logic [63:0] EXP_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] EXP_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;

    ysyx_22040088_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: architectural PC, accepted-but-unanswered fetch
    // addresses, and the most recent response paired with its request address.
    logic [63:0] m_pc = EXP_RESET_PC;
    logic [63:0] acc_q[$];
    logic [63:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic        prev_pending = 1'b0;
    logic [63:0] prev_addr = '0;
    logic        prev_id_valid = 1'b0;
    logic [63:0] prev_id_pc = '0;
    logic [31:0] prev_id_inst = '0;
    logic        drop_id = 1'b0;
    int          hs_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check("rst_id_valid", 64'(id_valid), 64'd0);
            check("rst_id_inst", 64'(id_inst), 64'(EXP_NOP));
            check("rst_id_pc", id_pc, 64'd0);
            m_pc = EXP_RESET_PC;
            acc_q.delete();
            last_addr = '0;
            last_data = '0;
            prev_pending = 1'b0;
            prev_id_valid = 1'b0;
            drop_id = 1'b0;
        end else begin
            if (!id_valid) check("idle_inst_nop", 64'(id_inst), 64'(EXP_NOP));
            check("no_req_while_holding", 64'(imem_req_valid & id_valid), 64'd0);

            if (drop_id) begin
                check("id_dropped", 64'(id_valid), 64'd0);
            end else if (prev_id_valid) begin
                check("id_held_valid", 64'(id_valid), 64'd1);
                check("id_held_pc", id_pc, prev_id_pc);
                check("id_held_inst", 64'(id_inst), 64'(prev_id_inst));
            end else if (id_valid) begin
                check("id_pc_vs_model", id_pc, m_pc);
                check("id_pc_vs_resp", id_pc, last_addr);
                check("id_inst_vs_resp", 64'(id_inst), 64'(last_data));
            end

            if (prev_pending) begin
                check("req_held", 64'(imem_req_valid), 64'd1);
                check("req_addr_stable", imem_addr, prev_addr);
            end else if (imem_req_valid) begin
                check("req_addr_vs_model", imem_addr, m_pc);
            end

            // Effects of the coming clock edge.
            if (imem_rvalid && acc_q.size() > 0) begin
                last_addr = acc_q.pop_front();
                last_data = imem_rdata;
            end
            if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_addr);
            drop_id = id_valid && (id_ready || redirect_valid);
            if (id_valid && id_ready && !redirect_valid) hs_cnt++;
            prev_pending  = imem_req_valid && !imem_req_ready;
            prev_addr     = imem_addr;
            prev_id_valid = id_valid;
            prev_id_pc    = id_pc;
            prev_id_inst  = id_inst;
            if (redirect_valid) m_pc = redirect_pc & ~64'h3;
            else if (id_valid && id_ready) m_pc = m_pc + 64'd4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step();
        int r;
        imem_req_ready = ($urandom_range(0, 3) != 0);
        if (acc_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
        end
        id_ready = ($urandom_range(0, 1) == 1);
        r = $urandom_range(0, 15);
        redirect_valid = (r == 0);
        if ($urandom_range(0, 9) == 0)
            redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        else
            redirect_pc = 64'h0000_0000_8000_0000 | 64'($urandom_range(0, 65535));
        tick();
    endtask

    task automatic zw_step();
        imem_req_ready = 1'b1;
        imem_rvalid    = (acc_q.size() > 0);
        imem_rdata     = $urandom;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int h0;
        int n;
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        tick();
        tick();

        // 1: first fetch after reset, zero-wait memory
        rst = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        check("t1_req_valid", 64'(imem_req_valid), 64'd1);
        check("t1_req_addr", imem_addr, 64'h8000_0000);
        tick();
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0010_0093;
        tick();
        imem_rvalid = 1'b0;
        check("t1_id_valid", 64'(id_valid), 64'd1);
        check("t1_id_pc", id_pc, 64'h8000_0000);
        check("t1_id_inst", 64'(id_inst), 64'h0010_0093);

        // 2: decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            check("t2_id_valid", 64'(id_valid), 64'd1);
            check("t2_id_pc", id_pc, 64'h8000_0000);
            check("t2_id_inst", 64'(id_inst), 64'h0010_0093);
            check("t2_no_req", 64'(imem_req_valid), 64'd0);
            tick();
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("t1_id_cleared", 64'(id_valid), 64'd0);
        check("t1_next_req_addr", imem_addr, 64'h8000_0004);

        // 3: memory stalls, redirect lands while the request is pending
        for (int i = 0; i < 4; i++) begin
            check("t3_req_valid", 64'(imem_req_valid), 64'd1);
            check("t3_req_addr", imem_addr, 64'h8000_0004);
            redirect_valid = (i == 1);
            redirect_pc = 64'h8000_0100;
            tick();
        end
        redirect_valid = 1'b0;
        check("t3_req_not_readdressed", imem_addr, 64'h8000_0004);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("t3_dropped", 64'(id_valid), 64'd0);
        check("t3_new_req_addr", imem_addr, 64'h8000_0100);

        // 4: redirect coincides with the response in WAIT
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0113;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0203;
        tick();
        imem_rvalid = 1'b0;
        redirect_valid = 1'b0;
        check("t4_no_id_valid", 64'(id_valid), 64'd0);
        check("t4_req_valid", 64'(imem_req_valid), 64'd1);
        check("t4_req_addr", imem_addr, 64'h8000_0200);

        // 5: redirect beats a same-cycle decode handshake
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0513;
        tick();
        imem_rvalid = 1'b0;
        check("t5_id_pc", id_pc, 64'h8000_0200);
        check("t5_id_inst", 64'(id_inst), 64'h0000_0513);
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0040;
        tick();
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        check("t5_id_cleared", 64'(id_valid), 64'd0);
        check("t5_req_addr", imem_addr, 64'h8000_0040);

        // 6: reset while waiting for a response, stale rvalid afterwards
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_async_req_valid", 64'(imem_req_valid), 64'd0);
        check("t6_async_id_inst", 64'(id_inst), 64'(EXP_NOP));
        tick();
        rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        check("t6_no_id_valid", 64'(id_valid), 64'd0);
        check("t6_req_addr", imem_addr, 64'h8000_0000);
        tick();
        imem_rvalid = 1'b0;
        check("t6_still_no_id", 64'(id_valid), 64'd0);
        check("t6_req_valid", 64'(imem_req_valid), 64'd1);

        // PC wraps past the top of the address space
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h00a0_0093;
        tick();
        imem_rvalid = 1'b0;
        check("wrap_first_pc", id_pc, 64'h8000_0000);
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("wrap_next_addr", imem_addr, 64'h0);

        // Randomized traffic, checked every cycle by the model
        h0 = hs_cnt;
        for (int i = 0; i < 3000; i++) rand_step();
        check("rand_progress", 64'(hs_cnt > h0), 64'd1);

        // Zero-wait memory sustains one instruction per three cycles
        h0 = hs_cnt;
        n = 0;
        while (hs_cnt == h0 && n < 40) begin
            zw_step();
            n++;
        end
        check("zw_started", 64'(hs_cnt != h0), 64'd1);
        h0 = hs_cnt;
        for (int i = 0; i < 30; i++) zw_step();
        check("zw_throughput", 64'(hs_cnt - h0), 64'd10);

        id_ready = 1'b0;
        imem_req_ready = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
